// File: rtl/sprite_fb_writer.sv
// sprite_fb_writer
// Sink for the one-pixel-per-clock stream of the sprite/boss drawers. Drops
// transparent and off-screen pixels, queues the rest as {page, offset, index}
// in a small FIFO, and writes them to the double-buffered frame buffer over a
// ready-handshaked port. Emits a single done pulse once the pass has fully
// drained into the frame buffer.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pix_valid/x/y/color   drawer pixel stream (color[6] = opaque, [5:0] = index)
//   src_done              upstream pass finished (1-cycle pulse)
//   page_sel              back-buffer page, captured per pixel at push
//   fb_addr/data/we       frame buffer write request, fb_ready accepts it
//   busy                  pass in progress or pixels still queued
//   done                  1-cycle pulse: pass fully committed
//   overflow              sticky: a pixel was lost to a full FIFO
//   write_count           writes committed this pass
//
// Build option: define FB_WRITE_COUNT_EN to implement write_count; otherwise
// it is tied to zero.
//
// State table:
//   IDLE   | waiting for a pass to start
//   STREAM | drawer emitting pixels
//   DRAIN  | drawer finished, waiting for the FIFO to empty
//   PULSE  | done asserted for one cycle

module sprite_fb_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [8:0]        pix_x,
    input  logic [7:0]        pix_y,
    input  logic [6:0]        pix_color,
    input  logic              src_done,
    input  logic              page_sel,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [5:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [16:0]       write_count
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             OFF_W   = ADDR_W - 1;
    localparam int             ENTRY_W = ADDR_W + 6;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [9:0]     X_LIM   = 10'(SCREEN_W);
    localparam logic [8:0]     Y_LIM   = 9'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, PULSE} state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count;
    logic               accept, full, empty, push, pop, fresh;
    logic [OFF_W-1:0]   offset;
    logic [ENTRY_W-1:0] head;

    // y*320 as two shifts keeps the multiply out of the datapath.
    assign offset = (OFF_W'(pix_y) << 8) + (OFF_W'(pix_y) << 6) + OFF_W'(pix_x);

    assign accept = pix_valid & pix_color[6] & ({1'b0, pix_x} < X_LIM) & ({1'b0, pix_y} < Y_LIM);
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign fb_we  = !empty;
    assign pop    = fb_we & fb_ready;
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    assign push   = accept & (!full | pop);

    // Storage is flops cleared by reset, so the head is a registered value and
    // the bus reads zero after reset.
    assign head    = mem[rd_ptr];
    assign fb_addr = head[ENTRY_W-1:6];
    assign fb_data = head[5:0];

    assign done = (state == PULSE);
    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {page_sel, offset, pix_color[5:0]};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A pixel arriving with src_done still has to drain first.
                if (src_done)       state_next = pix_valid ? DRAIN : PULSE;
                else if (pix_valid) state_next = STREAM;
            end
            STREAM: if (src_done) state_next = DRAIN;
            DRAIN:  if (empty && !push) state_next = PULSE;
            PULSE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // fresh marks that no pixel has been accepted since the last IDLE, so the
    // first accepted pixel of a new pass clears the sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            fresh    <= 1'b1;
        end else begin
            if (accept && !push)                          overflow <= 1'b1;
            else if (accept && (fresh || state == IDLE))  overflow <= 1'b0;

            if (accept)              fresh <= 1'b0;
            else if (state == IDLE)  fresh <= 1'b1;
        end
    end

`ifdef FB_WRITE_COUNT_EN
    localparam logic [16:0] WC_MAX = 17'(SCREEN_W * SCREEN_H);
    logic [16:0] wc_q;

    always_ff @(posedge clk) begin
        if (reset)                            wc_q <= '0;
        else if (state == IDLE && pix_valid)  wc_q <= '0;
        else if (pop && wc_q != WC_MAX)       wc_q <= wc_q + 1'b1;
    end

    assign write_count = wc_q;
`else
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_sprite_fb_writer.sv
module tb_sprite_fb_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [6:0]  pix_color = '0;
    logic        src_done = 1'b0;
    logic        page_sel = 1'b0;
    logic [17:0] fb_addr;
    logic [5:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [16:0] write_count;

    sprite_fb_writer dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_color(pix_color), .src_done(src_done),
        .page_sel(page_sel), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .fb_ready(fb_ready), .busy(busy), .done(done),
        .overflow(overflow), .write_count(write_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [23:0] wr_q[$];
    int done_cnt = 0;

    // Record committed writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (fb_we && fb_ready) wr_q.push_back({fb_addr, fb_data});
            if (done) done_cnt++;
        end
    end

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [6:0]  color;
        logic        page;
        logic        acc;
        logic [17:0] addr;
        logic [5:0]  data;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_wc(input int n);
`ifdef FB_WRITE_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic close_pass(input string name, input int w0, input int d0, input int exp_w);
        wait_done(60);
        tick();
        check({name, "_done_low"}, {31'b0, done}, 32'd0);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_writes"}, wr_q.size() - w0, exp_w);
        check({name, "_pulses"}, done_cnt - d0, 32'd1);
        check({name, "_wcount"}, {15'b0, write_count}, exp_wc(exp_w));
    endtask

    function automatic logic [23:0] wr_at(input int idx);
        if (idx < wr_q.size()) return wr_q[idx];
        return 'x;
    endfunction

    task automatic drive_pix(input logic [8:0] x, input logic [7:0] y, input logic [6:0] c, input logic pg);
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_color = c;
        page_sel  = pg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;

        vecs[0] = '{9'd10,  8'd2,   7'h45, 1'b1, 1'b1, 18'h2028A, 6'h05};
        vecs[1] = '{9'd0,   8'd0,   7'h7F, 1'b0, 1'b1, 18'h00000, 6'h3F};
        vecs[2] = '{9'd319, 8'd239, 7'h41, 1'b0, 1'b1, 18'h12BFF, 6'h01};
        vecs[3] = '{9'd319, 8'd239, 7'h41, 1'b1, 1'b1, 18'h32BFF, 6'h01};
        vecs[4] = '{9'd5,   8'd5,   7'h05, 1'b0, 1'b0, 18'h0,     6'h0};
        vecs[5] = '{9'd320, 8'd0,   7'h40, 1'b0, 1'b0, 18'h0,     6'h0};
        vecs[6] = '{9'd0,   8'd240, 7'h7F, 1'b0, 1'b0, 18'h0,     6'h0};
        vecs[7] = '{9'd511, 8'd255, 7'h7F, 1'b1, 1'b0, 18'h0,     6'h0};
        vecs[8] = '{9'd100, 8'd100, 7'h6A, 1'b0, 1'b1, 18'h07D64, 6'h2A};

        // Reset values
        tick();
        tick();
        check("rst_we",   {31'b0, fb_we}, 0);
        check("rst_addr", {14'b0, fb_addr}, 0);
        check("rst_data", {26'b0, fb_data}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_ovf",  {31'b0, overflow}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_wc",   {15'b0, write_count}, 0);
        reset = 1'b0;
        tick();

        // src_done in IDLE: done exactly one cycle later, no writes
        w0 = wr_q.size();
        d0 = done_cnt;
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        check("skip_done", {31'b0, done}, 1);
        tick();
        check("skip_done_low", {31'b0, done}, 0);
        check("skip_writes", wr_q.size() - w0, 0);
        check("skip_pulses", done_cnt - d0, 1);
        check("skip_wc", {15'b0, write_count}, 0);

        // Single-pixel passes
        for (int i = 0; i < 9; i++) begin
            w0 = wr_q.size();
            d0 = done_cnt;
            check("vec_idle_we", {31'b0, fb_we}, 0);
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].page);
            tick();
            pix_valid = 1'b0;
            check($sformatf("vec%0d_we", i), {31'b0, fb_we}, {31'b0, vecs[i].acc});
            if (vecs[i].acc) begin
                check($sformatf("vec%0d_addr", i), {14'b0, fb_addr}, {14'b0, vecs[i].addr});
                check($sformatf("vec%0d_data", i), {26'b0, fb_data}, {26'b0, vecs[i].data});
            end
            src_done = 1'b1;
            tick();
            src_done = 1'b0;
            close_pass($sformatf("vec%0d", i), w0, d0, vecs[i].acc ? 1 : 0);
        end

        // Overflow: 20 pixels with the frame buffer stalled
        w0 = wr_q.size();
        d0 = done_cnt;
        fb_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_pix(9'(k), 8'd1, 7'h40 | 7'(k), 1'b0);
            tick();
        end
        pix_valid = 1'b0;
        check("ovf_set", {31'b0, overflow}, 1);
        check("ovf_we", {31'b0, fb_we}, 1);
        check("ovf_head", {14'b0, fb_addr}, 320);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();
        check("ovf_hold_done", {31'b0, done}, 0);
        check("ovf_hold_busy", {31'b0, busy}, 1);
        fb_ready = 1'b1;
        close_pass("ovf", w0, d0, 16);
        for (int k = 0; k < 16; k++)
            check($sformatf("ovf_order%0d", k), {8'b0, wr_at(w0 + k)}, {8'b0, 18'(320 + k), 6'(k)});
        check("ovf_sticky", {31'b0, overflow}, 1);

        // Full FIFO with a pop in the same cycle: no drop
        w0 = wr_q.size();
        d0 = done_cnt;
        fb_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive_pix(9'(k), 8'd3, 7'h40 | 7'(k + 1), 1'b0);
            tick();
        end
        check("full_ovf_cleared", {31'b0, overflow}, 0);
        check("full_we", {31'b0, fb_we}, 1);
        drive_pix(9'd16, 8'd3, 7'h51, 1'b0);
        fb_ready = 1'b1;
        tick();
        pix_valid = 1'b0;
        check("full_nodrop_ovf", {31'b0, overflow}, 0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        close_pass("full", w0, d0, 17);
        check("full_last", {8'b0, wr_at(w0 + 16)}, {8'b0, 18'd976, 6'h11});

        // Mixed stream, last pixel coincides with src_done
        w0 = wr_q.size();
        d0 = done_cnt;
        drive_pix(9'd5, 8'd5, 7'h05, 1'b0);
        tick();
        drive_pix(9'd320, 8'd0, 7'h40, 1'b0);
        tick();
        drive_pix(9'd0, 8'd240, 7'h7F, 1'b0);
        tick();
        drive_pix(9'd319, 8'd239, 7'h41, 1'b0);
        src_done = 1'b1;
        tick();
        pix_valid = 1'b0;
        src_done = 1'b0;
        close_pass("mix", w0, d0, 1);
        check("mix_entry", {8'b0, wr_at(w0)}, {8'b0, 18'h12BFF, 6'h01});

        // Reset while draining five queued pixels
        w0 = wr_q.size();
        d0 = done_cnt;
        fb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_pix(9'(k), 8'd4, 7'h40 | 7'(k), 1'b1);
            tick();
        end
        pix_valid = 1'b0;
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        check("rd_busy_pre", {31'b0, busy}, 1);
        check("rd_we_pre", {31'b0, fb_we}, 1);
        reset = 1'b1;
        tick();
        check("rd_we",   {31'b0, fb_we}, 0);
        check("rd_busy", {31'b0, busy}, 0);
        check("rd_addr", {14'b0, fb_addr}, 0);
        check("rd_data", {26'b0, fb_data}, 0);
        check("rd_done", {31'b0, done}, 0);
        check("rd_ovf",  {31'b0, overflow}, 0);
        check("rd_wc",   {15'b0, write_count}, 0);
        reset = 1'b0;
        fb_ready = 1'b1;
        repeat (10) tick();
        check("rd_no_writes", wr_q.size() - w0, 0);
        check("rd_no_done", done_cnt - d0, 0);
        check("rd_idle_busy", {31'b0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
